// File: rtl/hazard_pkg.sv
// Shared types and constants for the forwarding/hazard controller.
package hazard_pkg;

    // ALU operand mux select encoding
    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF    = 2'b00;  // register file value
    localparam fwd_sel_t FWD_EXMEM = 2'b01;  // EX/MEM result
    localparam fwd_sel_t FWD_MEMWB = 2'b10;  // MEM/WB result

endpackage

// File: rtl/fwd_select.sv
// Priority forwarding compare for one ALU operand: the youngest producer (MEM) wins over WB.
// Register 0 is never forwarded, and an empty EX stage always selects the register file.
module fwd_select
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic              ex_v,
    input  logic [REG_AW-1:0] src,
    input  logic              mem_v,
    input  logic              mem_we,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              wb_v,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_rd,
    output fwd_sel_t          sel
);

    logic mem_hit;
    logic wb_hit;

    // Select the nearest older writer of src, if any
    always_comb begin
        mem_hit = mem_v && mem_we && (mem_rd != '0) && (mem_rd == src);
        wb_hit  = wb_v && wb_we && (wb_rd != '0) && (wb_rd == src);
        sel     = FWD_RF;
        if (ex_v) begin
            if (mem_hit) begin
                sel = FWD_EXMEM;
            end else if (wb_hit) begin
                sel = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller for the 5-stage pipeline.
// Keeps a shadow copy of EX/MEM/WB destination info fed from ID-stage fields.
// Optional feature: define HAZARD_STALL_CNT_EN to add the saturating stall_cnt output.
module fwd_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW = 5
`ifdef HAZARD_STALL_CNT_EN
    ,
    parameter int unsigned CNT_W  = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              flush,
    input  logic              hold,
    output fwd_sel_t          fwd_a,
    output fwd_sel_t          fwd_b,
    output logic              stall,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              idex_bubble
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rd;
        logic              we;
        logic              ld;
    } ex_stage_t;

    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] rd;
        logic              we;
    } late_stage_t;

    ex_stage_t   ex_q,  ex_d;
    late_stage_t mem_q, mem_d;
    late_stage_t wb_q,  wb_d;
    logic        load_use;

    fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
        .ex_v   (ex_q.v),
        .src    (ex_q.rs),
        .mem_v  (mem_q.v),
        .mem_we (mem_q.we),
        .mem_rd (mem_q.rd),
        .wb_v   (wb_q.v),
        .wb_we  (wb_q.we),
        .wb_rd  (wb_q.rd),
        .sel    (fwd_a)
    );

    fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
        .ex_v   (ex_q.v),
        .src    (ex_q.rt),
        .mem_v  (mem_q.v),
        .mem_we (mem_q.we),
        .mem_rd (mem_q.rd),
        .wb_v   (wb_q.v),
        .wb_we  (wb_q.we),
        .wb_rd  (wb_q.rd),
        .sel    (fwd_b)
    );

    // Load-use detection and pipeline control; flush and hold both override a stall
    always_comb begin
        load_use = id_valid && ex_q.v && ex_q.ld && ex_q.we && (ex_q.rd != '0) &&
                   ((id_use_rs && (id_rs == ex_q.rd)) || (id_use_rt && (id_rt == ex_q.rd)));
        stall       = load_use && !flush && !hold;
        pc_write    = !stall && !hold;
        ifid_write  = !stall && !hold;
        idex_bubble = (stall || flush) && !hold;
    end

    // Shadow pipeline advance; a stalled or flushed ID instruction enters EX as a bubble
    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (!hold) begin
            wb_d     = mem_q;
            mem_d.v  = ex_q.v;
            mem_d.rd = ex_q.rd;
            mem_d.we = ex_q.we;
            ex_d.v   = id_valid && !stall && !flush;
            ex_d.rs  = id_rs;
            ex_d.rt  = id_rt;
            ex_d.rd  = id_rd;
            ex_d.we  = id_reg_write;
            ex_d.ld  = id_mem_read;
        end
    end

    // Shadow stage registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of load-use stall cycles
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Stall counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Randomized self-checking bench for fwd_hazard_ctrl against an in-flight instruction model.
module tb_fwd_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic [4:0] id_rd;
    logic       id_reg_write;
    logic       id_mem_read;
    logic       flush;
    logic       hold;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       stall;
    logic       pc_write;
    logic       ifid_write;
    logic       idex_bubble;
`ifdef HAZARD_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    fwd_hazard_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .flush        (flush),
        .hold         (hold),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .stall        (stall),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .idex_bubble  (idex_bubble)
`ifdef HAZARD_STALL_CNT_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Model: instruction records in flight; slot 0 = EX, 1 = MEM, 2 = WB
    typedef struct {
        bit v;
        int rs;
        int rt;
        int rd;
        bit we;
        bit ld;
    } ins_t;

    ins_t pipe [3];
    int   model_cnt;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            pipe[i] = '{v: 0, rs: 0, rt: 0, rd: 0, we: 0, ld: 0};
        end
        model_cnt = 0;
    endfunction

    // Search older in-flight instructions, nearest first, for a writer of src
    function automatic int model_fwd(input int src);
        if (!pipe[0].v) return 0;
        for (int k = 1; k <= 2; k++) begin
            if (pipe[k].v && pipe[k].we && pipe[k].rd != 0 && pipe[k].rd == src) return k;
        end
        return 0;
    endfunction

    function automatic bit model_stall();
        bit uses;
        uses = (id_use_rs && int'(id_rs) == pipe[0].rd) || (id_use_rt && int'(id_rt) == pipe[0].rd);
        return id_valid && pipe[0].v && pipe[0].ld && pipe[0].we && pipe[0].rd != 0 && uses &&
               !flush && !hold;
    endfunction

    task automatic check_outputs(input string where);
        bit exp_stall;
        exp_stall = model_stall();
        check_eq({where, ".fwd_a"}, int'(fwd_a), model_fwd(pipe[0].rs));
        check_eq({where, ".fwd_b"}, int'(fwd_b), model_fwd(pipe[0].rt));
        check_eq({where, ".stall"}, int'(stall), int'(exp_stall));
        check_eq({where, ".pc_write"}, int'(pc_write), int'(!exp_stall && !hold));
        check_eq({where, ".ifid_write"}, int'(ifid_write), int'(!exp_stall && !hold));
        check_eq({where, ".idex_bubble"}, int'(idex_bubble), int'((exp_stall || flush) && !hold));
`ifdef HAZARD_STALL_CNT_EN
        check_eq({where, ".stall_cnt"}, int'(stall_cnt), model_cnt);
`endif
    endtask

    // Advance the model by one clock edge using the current ID inputs
    function automatic void model_step();
        bit s;
        s = model_stall();
        if (s && model_cnt != 65535) model_cnt++;
        if (!hold) begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = '{v: id_valid && !s && !flush, rs: int'(id_rs), rt: int'(id_rt),
                        rd: int'(id_rd), we: id_reg_write, ld: id_mem_read};
        end
    endfunction

    task automatic drive_idle();
        id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        id_rd = 0; id_reg_write = 0; id_mem_read = 0; flush = 0; hold = 0;
    endtask

    task automatic drive_random();
        id_valid     = ($urandom_range(0, 9) < 8);
        id_rs        = 5'($urandom_range(0, 3));
        id_rt        = 5'($urandom_range(0, 3));
        id_use_rs    = ($urandom_range(0, 4) != 0);
        id_use_rt    = ($urandom_range(0, 4) != 0);
        id_rd        = 5'($urandom_range(0, 3));
        id_reg_write = ($urandom_range(0, 4) != 0);
        id_mem_read  = ($urandom_range(0, 2) == 0);
        flush        = ($urandom_range(0, 9) == 0);
        hold         = ($urandom_range(0, 9) == 0);
    endtask

    initial begin
        drive_idle();
        rst = 1'b1;
        model_reset();
        #2;
        check_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Random traffic over a small register set so hazards are frequent
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            drive_random();
            #1;
            check_outputs("rand");
            model_step();
        end

        // Reset asserted while a load-use stall is active
        @(negedge clk);
        drive_idle();
        id_valid = 1; id_rd = 5'd2; id_reg_write = 1; id_mem_read = 1;
        #1;
        model_step();
        @(negedge clk);
        drive_idle();
        id_valid = 1; id_rs = 5'd2; id_rt = 5'd2; id_use_rs = 1; id_use_rt = 1;
        id_rd = 5'd6; id_reg_write = 1;
        #1;
        check_eq("pre_rst.stall", int'(stall), 1);
        check_outputs("pre_rst");
        rst = 1'b1;
        model_reset();
        #1;
        check_outputs("in_rst");
        @(negedge clk);
        rst = 1'b0;
        drive_idle();
        id_valid = 1; id_rs = 5'd2; id_rt = 5'd3; id_use_rs = 1; id_use_rt = 1;
        id_rd = 5'd4; id_reg_write = 1;
        #1;
        check_outputs("post_rst0");
        model_step();
        @(negedge clk);
        drive_idle();
        #1;
        check_outputs("post_rst1");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
